// File: rtl/imem_responder.sv
// imem_responder: memory side of the IMEM interface.
// Returns one registered 32-bit instruction word per read with one cycle of latency and holds it
// while the fetch stage stalls. A byte-serial loader fills the array (little-endian per word).
// Optional feature macro: IMEM_MISALIGN_EN adds misalign_o and zeroes misaligned reads.

module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [31:0]                  IMEM_addr_i,
    input  logic                         IMEM_read_n_i,
    output logic [31:0]                  IMEM_data_o,
    input  logic                         load_start_i,
    input  logic                         load_valid_i,
    input  logic [7:0]                   load_byte_i,
    output logic                         load_ready_o,
    output logic [$clog2(DEPTH_WORDS):0] load_words_o
`ifdef IMEM_MISALIGN_EN
    ,
    output logic                         misalign_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_IDX = DEPTH_WORDS[29:0];
    localparam logic [AW:0] DEPTH_CNT = DEPTH_WORDS[AW:0];

    typedef enum logic [0:0] {StCollect, StWrite} load_state_e;

    // Instruction array; deliberately not reset so it maps onto block RAM.
    logic [31:0] mem [DEPTH_WORDS];

    // Read-side address decode
    logic [31:0]   offset;
    logic [29:0]   idx;
    logic          in_range;
    logic [AW-1:0] rd_idx;
    logic          unused_offset_bits;

    assign offset   = IMEM_addr_i - BASE_ADDR;
    assign idx      = offset[31:2];
    // Addresses below the base wrap to huge offsets; the explicit compare rejects them.
    assign in_range = (IMEM_addr_i >= BASE_ADDR) && (idx < DEPTH_IDX);
    assign rd_idx   = idx[AW-1:0];
    assign unused_offset_bits = ^offset[1:0];

    // Loader state
    load_state_e   state_q, state_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [31:0]   stage_q, stage_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   words_q, words_d;
    logic          mem_we;

    // Loader next-state: load_start_i overrides everything, including a pending write.
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        stage_d  = stage_q;
        wr_ptr_d = wr_ptr_q;
        words_d  = words_q;
        mem_we   = 1'b0;
        if (load_start_i) begin
            state_d  = StCollect;
            bcnt_d   = 2'd0;
            wr_ptr_d = '0;
            words_d  = '0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (load_valid_i) begin
                        stage_d[{bcnt_q, 3'b000} +: 8] = load_byte_i;
                        if (bcnt_q == 2'd3) begin
                            state_d = StWrite;
                            bcnt_d  = 2'd0;
                        end else begin
                            bcnt_d = bcnt_q + 2'd1;
                        end
                    end
                end
                StWrite: begin
                    mem_we   = 1'b1;
                    // Power-of-two depth: natural overflow wraps the pointer.
                    wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
                    if (words_q != DEPTH_CNT) begin
                        words_d = words_q + {{AW{1'b0}}, 1'b1};
                    end
                    state_d = StCollect;
                end
                default: state_d = StCollect;
            endcase
        end
    end

    // Loader registers; a reset mid-word discards the partial staging word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StCollect;
            bcnt_q   <= 2'd0;
            stage_q  <= 32'h0;
            wr_ptr_q <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            stage_q  <= stage_d;
            wr_ptr_q <= wr_ptr_d;
            words_q  <= words_d;
        end
    end

    assign load_ready_o = (state_q == StCollect);
    assign load_words_o = words_q;

    // Array write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= stage_q;
        end
    end

    // Registered read port; non-blocking update gives read-first on a same-word collision.
`ifdef IMEM_MISALIGN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            IMEM_data_o <= 32'h0;
            misalign_o  <= 1'b0;
        end else if (!IMEM_read_n_i) begin
            if (IMEM_addr_i[1:0] != 2'b00) begin
                IMEM_data_o <= 32'h0;
                misalign_o  <= 1'b1;
            end else begin
                IMEM_data_o <= in_range ? mem[rd_idx] : 32'h0;
                misalign_o  <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            IMEM_data_o <= 32'h0;
        end else if (!IMEM_read_n_i) begin
            IMEM_data_o <= in_range ? mem[rd_idx] : 32'h0;
        end
    end
`endif

endmodule
